icache: RTL

Direct-mapped, one-word-per-line instruction cache between the instruction fetch unit and the memory controller's instruction port. A fetch request is served one cycle later on a hit. On a miss, one 32-bit word fetch is issued to the memory controller, the line is filled, and the instruction is returned. The block is the initiator on the memory controller's level-request / one-cycle-done instruction handshake.

---
 rtl/icache_pkg.sv | 20 ++
 rtl/icache_if.sv | 26 ++
 rtl/icache_array.sv | 47 ++++
 rtl/icache.sv | 100 ++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
// Address/word widths are fixed; line count is a parameter of the top.
package icache_pkg;

   localparam int ADDR_W = 32;
   localparam int WORD_W = 32;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   typedef enum logic {
      IDLE = 1'b0,
      MISS = 1'b1
   } state_t;

   function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
      return {addr[ADDR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side handshake signals of the instruction cache.
// The cache uses the slave modport; the fetch unit plus memory controller use master.
interface icache_if;
   import icache_pkg::*;

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_clear;
   logic              if_done;
   logic [WORD_W-1:0] if_ins;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_done;
   logic [WORD_W-1:0] mem_ins;

   modport slave (
      input  if_req, if_addr, if_clear, mem_done, mem_ins,
      output if_done, if_ins, mem_req, mem_addr
   );

   modport master (
      output if_req, if_addr, if_clear, mem_done, mem_ins,
      input  if_done, if_ins, mem_req, mem_addr
   );

endinterface

// File: rtl/icache_array.sv
// Line storage: resettable valid vector plus tag and data RAMs.
// One combinational read port and one synchronous write port.
module icache_array
   import icache_pkg::*;
#(
   parameter int INDEX_BITS = 8,
   parameter int TAG_BITS   = ADDR_W - INDEX_BITS - 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [INDEX_BITS-1:0] rd_index,
   output logic                  rd_valid,
   output logic [TAG_BITS-1:0]   rd_tag,
   output logic [WORD_W-1:0]     rd_data,
   input  logic                  wr_en,
   input  logic [INDEX_BITS-1:0] wr_index,
   input  logic [TAG_BITS-1:0]   wr_tag,
   input  logic [WORD_W-1:0]     wr_data
);

   localparam int LINES = 1 << INDEX_BITS;

   logic [LINES-1:0]    valid;
   logic [TAG_BITS-1:0] tag_ram  [LINES];
   logic [WORD_W-1:0]   data_ram [LINES];

   // Only the valid bits need clearing; stale tags and data are never trusted.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= '0;
      end else if (wr_en) begin
         valid[wr_index] <= TRUE;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_ram[wr_index]  <= wr_tag;
         data_ram[wr_index] <= wr_data;
      end
   end

   assign rd_valid = valid[rd_index];
   assign rd_tag   = tag_ram[rd_index];
   assign rd_data  = data_ram[rd_index];

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache: IDLE/MISS control,
// hit compare, flush-drop tracking and registered fetch-side outputs.
module icache
   import icache_pkg::*;
#(
   parameter int INDEX_BITS = 8
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     rdy,
   icache_if.slave  bus
);

   localparam int TAG_BITS = ADDR_W - INDEX_BITS - 2;

   state_t              state;
   logic                drop;
   logic [ADDR_W-1:0]   miss_addr;
   logic                if_done_q;
   logic [WORD_W-1:0]   if_ins_q;

   logic [INDEX_BITS-1:0] req_index;
   logic [TAG_BITS-1:0]   req_tag;
   logic [INDEX_BITS-1:0] fill_index;
   logic [TAG_BITS-1:0]   fill_tag;
   logic                  rd_valid;
   logic [TAG_BITS-1:0]   rd_tag;
   logic [WORD_W-1:0]     rd_data;
   logic                  hit;
   logic                  fill_en;

   assign req_index  = bus.if_addr[INDEX_BITS+1:2];
   assign req_tag    = bus.if_addr[ADDR_W-1:INDEX_BITS+2];
   assign fill_index = miss_addr[INDEX_BITS+1:2];
   assign fill_tag   = miss_addr[ADDR_W-1:INDEX_BITS+2];
   assign hit        = rd_valid && (rd_tag == req_tag);

   // A fill coinciding with reset is discarded along with the miss.
   assign fill_en = rdy && !rst && (state == MISS) && bus.mem_done;

   icache_array #(
      .INDEX_BITS (INDEX_BITS),
      .TAG_BITS   (TAG_BITS)
   ) u_array (
      .clk      (clk),
      .rst      (rst),
      .rd_index (req_index),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_data  (rd_data),
      .wr_en    (fill_en),
      .wr_index (fill_index),
      .wr_tag   (fill_tag),
      .wr_data  (bus.mem_ins)
   );

   // Request drops in the done cycle so the controller never starts a second fetch.
   assign bus.mem_req  = (state == MISS) && !bus.mem_done;
   assign bus.mem_addr = (state == MISS) ? miss_addr : '0;
   assign bus.if_done  = if_done_q;
   assign bus.if_ins   = if_ins_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         drop      <= FALSE;
         miss_addr <= '0;
         if_done_q <= FALSE;
         if_ins_q  <= '0;
      end else if (rdy) begin
         if_done_q <= FALSE;
         case (state)
            IDLE: begin
               if (bus.if_req && !bus.if_clear) begin
                  if (hit) begin
                     if_done_q <= TRUE;
                     if_ins_q  <= rd_data;
                  end else begin
                     miss_addr <= word_align(bus.if_addr);
                     drop      <= FALSE;
                     state     <= MISS;
                  end
               end
            end
            MISS: begin
               // The memory transaction cannot be aborted, so a flush only hides the result.
               if (bus.mem_done) begin
                  if_ins_q  <= bus.mem_ins;
                  if_done_q <= !(drop || bus.if_clear);
                  state     <= IDLE;
               end else if (bus.if_clear) begin
                  drop <= TRUE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
